i2c_byte_master: RTL

Byte-level I2C master sequencer that generates SCL and drives the SDA selector's data, acknowledge and phase-select inputs. It executes one command per transaction: START, 7-bit address plus R/W bit, N data bytes, STOP. Data and acknowledge bits flow through the downstream SDA selector, which owns the SDA pad. The selector is the block's only consumer on the bus side.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_quarter_timer.sv | 45 ++++
 rtl/i2c_byte_master.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C byte master.
//   i2c_state_t : sequencer state encoding
//   SEL_*       : {sel_ack, sel_dir} codes driven to the SDA selector
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      AACK,
      WRITE,
      WACK,
      READ,
      RACK,
      STOP
   } i2c_state_t;

   localparam logic [1:0] SEL_M_DATA = 2'b00;  // master drives data bit
   localparam logic [1:0] SEL_S_DATA = 2'b01;  // slave drives data bit
   localparam logic [1:0] SEL_M_ACK  = 2'b10;  // master drives ack bit
   localparam logic [1:0] SEL_S_ACK  = 2'b11;  // slave drives ack bit

endpackage

// File: rtl/i2c_quarter_timer.sv
// i2c_quarter_timer: divides clk into SCL quarter periods.
//   clk, rst        : system clock, async active-high reset
//   en_i            : count enable; when low the prescaler and quarter index hold at 0
//   tick_o          : last clk of the current quarter
//   pre_tick_o      : second-to-last clk of the current quarter
//   q_o             : quarter index 0..3 within the bit
//   last_q2_clk_o   : last clk of quarter 2 (input sampling point)
module i2c_quarter_timer #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   output logic       tick_o,
   output logic       pre_tick_o,
   output logic [1:0] q_o,
   output logic       last_q2_clk_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [1:0]    q_q;

   assign tick_o        = (cnt_q == CW'(CLK_DIV - 1));
   assign pre_tick_o    = (cnt_q == CW'(CLK_DIV - 2));
   assign q_o           = q_q;
   assign last_q2_clk_o = tick_o && (q_q == 2'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         q_q   <= '0;
      end else if (!en_i) begin
         cnt_q <= '0;
         q_q   <= '0;
      end else if (tick_o) begin
         cnt_q <= '0;
         q_q   <= q_q + 2'd1;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master sequencer.
// Runs one command per transaction: START, {addr,rw}, nbytes data bytes, STOP.
// SDA itself lives in the downstream selector; this block drives its data,
// ack and phase-select inputs and generates SCL.
//   cmd_*        : command handshake (accepted only in IDLE)
//   wr_data/req  : write byte source; wr_data captured on the wr_req clk
//   rd_data/valid: received byte and its update strobe
//   done         : pulse on the last clk of STOP
//   nack_err     : sticky slave-NACK flag, cleared on the next accept
//   scl          : bus clock
//   sda_dout/din : master-driven / slave-driven data bit
//   master_ack   : ack bit driven by master (0 = ACK)
//   slave_ack    : ack bit from slave (0 = ACK)
//   sel_ack/dir  : selector phase select
module i2c_byte_master
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 250,
   parameter int unsigned NB_W    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [6:0]      cmd_addr,
   input  logic            cmd_rw,
   input  logic [NB_W-1:0] cmd_nbytes,
   input  logic [7:0]      wr_data,
   output logic            wr_req,
   output logic [7:0]      rd_data,
   output logic            rd_valid,
   output logic            done,
   output logic            nack_err,
   output logic            scl,
   output logic            sda_dout,
   input  logic            sda_din,
   output logic            master_ack,
   input  logic            slave_ack,
   output logic            sel_ack,
   output logic            sel_dir
);

   i2c_state_t      state_q;
   logic            scl_q, sda_q, mack_q, ack_q, rw_q;
   logic [1:0]      sel_q;
   logic [7:0]      shift_q, rd_data_q;
   logic [2:0]      bit_q;
   logic [NB_W-1:0] bytes_q;
   logic            rd_valid_q, wr_req_q, done_q, nack_q;

   logic       tick, pre_tick, last_q2;
   logic [1:0] q;
   logic       bit_end;

   i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk          (clk),
      .rst          (rst),
      .en_i         (state_q != IDLE),
      .tick_o       (tick),
      .pre_tick_o   (pre_tick),
      .q_o          (q),
      .last_q2_clk_o(last_q2)
   );

   assign bit_end = tick && (q == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         scl_q      <= 1'b1;
         sda_q      <= 1'b1;
         sel_q      <= SEL_M_DATA;
         mack_q     <= 1'b1;
         ack_q      <= 1'b0;
         rw_q       <= 1'b0;
         shift_q    <= '0;
         rd_data_q  <= '0;
         bit_q      <= '0;
         bytes_q    <= '0;
         rd_valid_q <= 1'b0;
         wr_req_q   <= 1'b0;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         wr_req_q   <= 1'b0;
         done_q     <= 1'b0;
         if (state_q == IDLE) begin
            if (cmd_valid) begin
               shift_q <= {cmd_addr, cmd_rw};
               rw_q    <= cmd_rw;
               bytes_q <= cmd_nbytes;
               nack_q  <= 1'b0;
               bit_q   <= '0;
               state_q <= START;
            end
         end else begin
            // Write byte arrives on the wr_req clk, so its MSB reaches SDA
            // one clk into q0 while SCL is still low.
            if (wr_req_q) begin
               shift_q <= wr_data;
               sda_q   <= wr_data[7];
            end
            if (last_q2) begin
               if (state_q == READ) begin
                  shift_q <= {shift_q[6:0], sda_din};
                  if (bit_q == 3'd7) begin
                     rd_data_q  <= {shift_q[6:0], sda_din};
                     rd_valid_q <= 1'b1;
                  end
               end
               if (state_q inside {AACK, WACK}) ack_q <= slave_ack;
            end
            // q2 entry: SCL rises; START/STOP move SDA here with SCL high.
            if (tick && q == 2'd1) begin
               scl_q <= 1'b1;
               if (state_q == START) sda_q <= 1'b0;
               if (state_q == STOP)  sda_q <= 1'b1;
            end
            // done registered one clk early so it lands on the bit's last clk
            if (state_q == STOP && q == 2'd3 && pre_tick) done_q <= 1'b1;
            if (bit_end) begin
               // defaults for the next bit's q0
               scl_q  <= 1'b0;
               sda_q  <= 1'b1;
               sel_q  <= SEL_M_DATA;
               mack_q <= 1'b1;
               case (state_q)
                  START: begin
                     state_q <= ADDR;
                     sda_q   <= shift_q[7];
                  end
                  ADDR, WRITE: begin
                     if (bit_q == 3'd7) begin
                        state_q <= (state_q == ADDR) ? AACK : WACK;
                        sel_q   <= SEL_S_ACK;
                        bit_q   <= '0;
                     end else begin
                        bit_q   <= bit_q + 3'd1;
                        shift_q <= {shift_q[6:0], 1'b0};
                        sda_q   <= shift_q[6];
                     end
                  end
                  AACK: begin
                     if (ack_q) begin
                        nack_q  <= 1'b1;
                        state_q <= STOP;
                        sda_q   <= 1'b0;
                     end else if (bytes_q == '0) begin
                        state_q <= STOP;
                        sda_q   <= 1'b0;
                     end else if (rw_q) begin
                        state_q <= READ;
                        sel_q   <= SEL_S_DATA;
                     end else begin
                        state_q  <= WRITE;
                        wr_req_q <= 1'b1;
                     end
                  end
                  WACK: begin
                     if (ack_q) begin
                        nack_q  <= 1'b1;
                        state_q <= STOP;
                        sda_q   <= 1'b0;
                     end else begin
                        bytes_q <= bytes_q - NB_W'(1);
                        if (bytes_q != NB_W'(1)) begin
                           state_q  <= WRITE;
                           wr_req_q <= 1'b1;
                        end else begin
                           state_q <= STOP;
                           sda_q   <= 1'b0;
                        end
                     end
                  end
                  READ: begin
                     if (bit_q == 3'd7) begin
                        state_q <= RACK;
                        sel_q   <= SEL_M_ACK;
                        mack_q  <= (bytes_q > NB_W'(1)) ? 1'b0 : 1'b1;
                        bit_q   <= '0;
                     end else begin
                        bit_q <= bit_q + 3'd1;
                        sel_q <= SEL_S_DATA;
                     end
                  end
                  RACK: begin
                     bytes_q <= bytes_q - NB_W'(1);
                     if (bytes_q != NB_W'(1)) begin
                        state_q <= READ;
                        sel_q   <= SEL_S_DATA;
                     end else begin
                        state_q <= STOP;
                        sda_q   <= 1'b0;
                     end
                  end
                  STOP: begin
                     state_q <= IDLE;
                     scl_q   <= 1'b1;
                  end
                  default: state_q <= IDLE;
               endcase
            end
         end
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign wr_req     = wr_req_q;
   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign done       = done_q;
   assign nack_err   = nack_q;
   assign scl        = scl_q;
   assign sda_dout   = sda_q;
   assign master_ack = mack_q;
   assign sel_ack    = sel_q[1];
   assign sel_dir    = sel_q[0];

endmodule
